// File: rtl/led_pkg.sv
// Shared types and constants for the LED running-light speed/direction control
// and the downstream shifter.
package led_pkg;

    localparam int SPEED_W = 2;
    localparam int TICK_W  = 25;
    localparam int CNT_W   = 20;

    localparam logic LED_DIR_LEFT  = 1'b0;
    localparam logic LED_DIR_RIGHT = 1'b1;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        PRESS_FLT = 2'd1,
        DOWN      = 2'd2,
        REL_FLT   = 2'd3
    } deb_state_e;

    // Step period for a speed level; each level halves the slowest period.
    function automatic logic [TICK_W-1:0] tick_period(input logic [TICK_W-1:0] base,
                                                      input logic [SPEED_W-1:0] speed);
        return base >> speed;
    endfunction

endpackage

// File: rtl/key_debounce.sv
// Single active-low key: 2-flop synchroniser, press/release filter FSM and window counter.
// Exposes the DOWN state only when LED_SPEED_PAUSE_EN is defined (used for key chords).
//
//   state     | meaning
//   IDLE      | key released and stable
//   PRESS_FLT | key seen low, waiting for a full window of low
//   DOWN      | press confirmed, key held
//   REL_FLT   | key seen high, waiting for a full window of high
module key_debounce
    import led_pkg::*;
#(
    parameter logic [CNT_W-1:0] CNT_20MS = 20'd999_999
) (
    input  logic sys_clk,
    input  logic sys_rst_n,
    input  logic key_i,
    output logic flag_o
`ifdef LED_SPEED_PAUSE_EN
    ,
    output logic down_o
`endif
);

    logic             sync1_q;
    logic             key_s_q;
    deb_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             flag_q, flag_d;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            sync1_q <= 1'b1;
            key_s_q <= 1'b1;
            state_q <= IDLE;
            cnt_q   <= '0;
            flag_q  <= 1'b0;
        end else begin
            sync1_q <= key_i;
            key_s_q <= sync1_q;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            flag_q  <= flag_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        flag_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (!key_s_q) begin
                    state_d = PRESS_FLT;
                    cnt_d   = '0;
                end
            end
            PRESS_FLT: begin
                if (key_s_q) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q >= CNT_20MS) begin
                    state_d = DOWN;
                    cnt_d   = '0;
                    flag_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DOWN: begin
                if (key_s_q) begin
                    state_d = REL_FLT;
                    cnt_d   = '0;
                end
            end
            REL_FLT: begin
                if (!key_s_q) begin
                    state_d = DOWN;
                    cnt_d   = '0;
                end else if (cnt_q >= CNT_20MS) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    assign flag_o = flag_q;
`ifdef LED_SPEED_PAUSE_EN
    assign down_o = (state_q == DOWN);
`endif

endmodule

// File: rtl/led_speed_ctrl.sv
// Key-driven speed/direction control and step-tick generator for the 4-LED shifter.
// Optional pause (key chord) feature is compiled in with LED_SPEED_PAUSE_EN.
module led_speed_ctrl
    import led_pkg::*;
#(
    parameter logic [CNT_W-1:0]  CNT_20MS  = 20'd999_999,
    parameter logic [TICK_W-1:0] TICK_BASE = 25'd24_999_999
) (
    input  logic               sys_clk,
    input  logic               sys_rst_n,
    input  logic [1:0]         key_in,
    output logic [1:0]         key_flag,
    output logic [SPEED_W-1:0] speed_sel,
    output logic               dir_out,
    output logic               paused,
    output logic               tick_out
);

    logic [1:0]         flag;
    logic [SPEED_W-1:0] speed_q, speed_d;
    logic               dir_q, dir_d;
    logic [TICK_W-1:0]  cnt_q, cnt_d;
    logic               tick_q, tick_d;
    logic [TICK_W-1:0]  period;
    logic               pause_hold;

`ifdef LED_SPEED_PAUSE_EN
    logic [1:0] down;
    logic       paused_q, paused_d;
`endif

    for (genvar i = 0; i < 2; i++) begin : g_key
        key_debounce #(
            .CNT_20MS(CNT_20MS)
        ) u_deb (
            .sys_clk  (sys_clk),
            .sys_rst_n(sys_rst_n),
            .key_i    (key_in[i]),
            .flag_o   (flag[i])
`ifdef LED_SPEED_PAUSE_EN
            ,
            .down_o   (down[i])
`endif
        );
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            speed_q <= '0;
            dir_q   <= LED_DIR_LEFT;
            cnt_q   <= '0;
            tick_q  <= 1'b0;
        end else begin
            speed_q <= speed_d;
            dir_q   <= dir_d;
            cnt_q   <= cnt_d;
            tick_q  <= tick_d;
        end
    end

`ifdef LED_SPEED_PAUSE_EN
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) paused_q <= 1'b0;
        else            paused_q <= paused_d;
    end
`endif

    always_comb begin
        speed_d = speed_q;
        dir_d   = dir_q;
`ifdef LED_SPEED_PAUSE_EN
        // A flag while the other key is held is a chord: toggle pause, drop the normal action.
        paused_d = paused_q;
        if ((flag[0] && down[1]) || (flag[1] && down[0])) paused_d = ~paused_q;
        if (flag[0] && !down[1]) speed_d = speed_q + SPEED_W'(1);
        if (flag[1] && !down[0]) dir_d = ~dir_q;
        pause_hold = paused_q | paused_d;
`else
        if (flag[0]) speed_d = speed_q + SPEED_W'(1);
        if (flag[1]) dir_d = ~dir_q;
        pause_hold = 1'b0;
`endif

        // Speed change and pause restart the period from zero so the first tick is a full period out.
        period = tick_period(TICK_BASE, speed_q);
        tick_d = 1'b0;
        if ((speed_d != speed_q) || pause_hold) begin
            cnt_d = '0;
        end else if (cnt_q >= period) begin
            cnt_d  = '0;
            tick_d = 1'b1;
        end else begin
            cnt_d = cnt_q + TICK_W'(1);
        end
    end

    assign key_flag  = flag;
    assign speed_sel = speed_q;
    assign dir_out   = dir_q;
    assign tick_out  = tick_q;
`ifdef LED_SPEED_PAUSE_EN
    assign paused    = paused_q;
`else
    assign paused    = 1'b0;
`endif

endmodule
